smart_camera: RTL and testbench

SMART_CAMERA -- requirements
Module: smart_camera

---
 rtl/smart_camera.sv | 78 +++++++
 tb/tb_smart_camera.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/smart_camera.sv
// rtl/smart_camera.sv - pan camera driven by synchronized motion and remote-control events
// Remote events step the angle and open a hold window that discards motion events.
module smart_camera #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       motion_detected,
    input  logic       remote_control,
    output logic [1:0] camera_angle
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);

    logic [1:0] rst_sync;
    logic       rst_int;
    logic [2:0] motion_sync;
    logic [2:0] remote_sync;
    logic       motion_ev;
    logic       remote_ev;
    logic [7:0] hold_cnt;
    logic       dir_up;

    // Asynchronous assertion, release retimed through two flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int = rst_sync[1];

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            motion_sync <= 3'b000;
            remote_sync <= 3'b000;
        end else begin
            motion_sync <= {motion_sync[1:0], motion_detected};
            remote_sync <= {remote_sync[1:0], remote_control};
        end
    end

    assign motion_ev = motion_sync[1] & ~motion_sync[2];
    assign remote_ev = remote_sync[1] & ~remote_sync[2];

    // Remote wins over a coincident motion event; motion during hold is dropped.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            camera_angle <= 2'd0;
            dir_up       <= 1'b1;
            hold_cnt     <= 8'd0;
        end else if (remote_ev) begin
            camera_angle <= camera_angle + 2'd1;
            hold_cnt     <= HOLD_LOAD;
        end else if (hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
        end else if (motion_ev) begin
            if (dir_up) begin
                if (camera_angle == 2'd3) begin
                    camera_angle <= 2'd2;
                    dir_up       <= 1'b0;
                end else begin
                    camera_angle <= camera_angle + 2'd1;
                end
            end else begin
                if (camera_angle == 2'd0) begin
                    camera_angle <= 2'd1;
                    dir_up       <= 1'b1;
                end else begin
                    camera_angle <= camera_angle - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_smart_camera.sv
// tb/tb_smart_camera.sv - self-checking bench for smart_camera
// Pulse table with a queue of expected angles plus hand-written reset and level-hold sequences.
module tb_smart_camera;

    logic       clk;
    logic       rst;
    logic       motion_detected;
    logic       remote_control;
    logic [1:0] camera_angle;

    int total;
    int bad;

    typedef struct {
        logic       motion;
        logic       remote;
        int         gap;
        logic [1:0] exp_angle;
    } vec_t;

    vec_t       vecs[$];
    logic [1:0] sb_q[$];

    smart_camera #(.HOLD_CYCLES(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .motion_detected(motion_detected),
        .remote_control (remote_control),
        .camera_angle   (camera_angle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] exp_angle);
        total++;
        if (camera_angle !== exp_angle) begin
            bad++;
            $display("FAIL %s: camera_angle=%0d expected=%0d at %0t", name, camera_angle, exp_angle, $time);
        end
    endtask

    task automatic add(input logic m, input logic r, input int gap, input logic [1:0] e);
        vec_t v;
        v.motion    = m;
        v.remote    = r;
        v.gap       = gap;
        v.exp_angle = e;
        vecs.push_back(v);
    endtask

    // Called at a negedge: one-period pulse, wait gap cycles, then compare.
    task automatic apply(input logic m, input logic r, input int gap, input logic [1:0] e, input string name);
        motion_detected = m;
        remote_control  = r;
        sb_q.push_back(e);
        @(negedge clk);
        motion_detected = 1'b0;
        remote_control  = 1'b0;
        repeat (gap - 1) @(negedge clk);
        check(name, sb_q.pop_front());
    endtask

    // Called at a negedge; leaves the bench at a negedge with the design out of reset.
    task automatic do_reset(input string name, input int settle);
        rst = 1'b0;
        #1;
        check(name, 2'd0);
        #9;
        rst = 1'b1;
        repeat (settle) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total           = 0;
        bad             = 0;
        rst             = 1'b1;
        motion_detected = 1'b0;
        remote_control  = 1'b0;

        // Start at angle 0, direction up, hold expired.
        add(1, 0, 4, 2'd1);
        add(1, 0, 4, 2'd2);
        add(1, 0, 4, 2'd3);
        add(1, 0, 4, 2'd2);
        add(1, 0, 4, 2'd1);
        add(1, 0, 4, 2'd0);
        add(1, 0, 4, 2'd1);
        add(1, 0, 4, 2'd2);
        add(1, 0, 4, 2'd3);
        add(0, 1, 3, 2'd0);   // remote wraps 3 -> 0
        add(1, 0, 11, 2'd0);  // motion 3 cycles into hold: dropped
        add(1, 0, 4, 2'd1);   // direction still up
        add(1, 1, 3, 2'd2);   // simultaneous: remote only
        add(1, 0, 11, 2'd2);  // hold loaded by simultaneous remote
        add(1, 0, 4, 2'd3);
        add(1, 0, 4, 2'd2);   // bounce, direction now down
        add(0, 1, 9, 2'd3);
        add(1, 0, 4, 2'd2);   // 9 cycles after remote: accepted, still down
        add(0, 1, 8, 2'd3);
        add(1, 0, 4, 2'd3);   // 8 cycles after remote: dropped
        add(1, 0, 4, 2'd2);
        add(0, 1, 6, 2'd3);
        add(0, 1, 6, 2'd0);   // remote inside hold reloads counter
        add(1, 0, 11, 2'd0);  // would be free without reload
        add(1, 0, 4, 2'd1);   // down from 0 turns up
        add(1, 0, 4, 2'd2);

        #2;
        rst = 1'b0;
        #1;
        check("reset_async", 2'd0);
        #9;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("after_release", 2'd0);
        repeat (20) @(negedge clk);
        check("idle_hold", 2'd0);

        // Exact latency of a single motion pulse.
        motion_detected = 1'b1;
        @(negedge clk);
        motion_detected = 1'b0;
        @(negedge clk);
        check("latency_before", 2'd0);
        @(negedge clk);
        check("latency_after", 2'd1);
        repeat (10) @(negedge clk);
        check("single_stays", 2'd1);

        do_reset("reset_again", 5);
        check("reset_again_idle", 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].motion, vecs[i].remote, vecs[i].gap, vecs[i].exp_angle, $sformatf("vec%0d", i));
        end

        // Levels held high produce one event each.
        motion_detected = 1'b1;
        repeat (5) @(negedge clk);
        check("motion_level_step", 2'd3);
        repeat (15) @(negedge clk);
        motion_detected = 1'b0;
        check("motion_level_once", 2'd3);
        repeat (5) @(negedge clk);
        check("motion_level_after", 2'd3);
        remote_control = 1'b1;
        repeat (20) @(negedge clk);
        remote_control = 1'b0;
        check("remote_level_once", 2'd0);
        repeat (12) @(negedge clk);

        // Reset inside an active hold clears it.
        apply(0, 1, 3, 2'd1, "remote_before_reset");
        do_reset("reset_mid_hold", 3);
        apply(1, 0, 4, 2'd1, "motion_after_reset");

        // Input already high when reset releases.
        motion_detected = 1'b1;
        do_reset("reset_with_input_high", 8);
        check("event_from_high_input", 2'd1);
        motion_detected = 1'b0;
        repeat (5) @(negedge clk);
        check("high_input_single", 2'd1);

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
